// File: rtl/softmax_seq_if.sv
// Handshake and memory/control bus between the softmax phase sequencer and
// the datapath. The sequencer is the slave: it takes start, drives the rest.
interface softmax_seq_if #(
  parameter int AW = 10
);
  logic          start;
  logic          busy;
  logic          done;
  logic [1:0]    phase;
  logic [AW-1:0] rd_addr;
  logic          im1_wr_ena;
  logic [AW-1:0] im1_wr_addr;
  logic [AW-1:0] im1_rd_addr;
  logic          im2_wr_ena;
  logic [AW-1:0] im2_wr_addr;
  logic [AW-1:0] im2_rd_addr;
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [1:0]    scale_update;
  logic          scale_lock;
  logic          acc_clr;
  logic          acc_pulse;

  modport master (
    output start,
    input  busy, done, phase, rd_addr, im1_wr_ena, im1_wr_addr, im1_rd_addr,
           im2_wr_ena, im2_wr_addr, im2_rd_addr, wr_ena, wr_addr,
           scale_update, scale_lock, acc_clr, acc_pulse
  );

  modport slave (
    input  start,
    output busy, done, phase, rd_addr, im1_wr_ena, im1_wr_addr, im1_rd_addr,
           im2_wr_ena, im2_wr_addr, im2_rd_addr, wr_ena, wr_addr,
           scale_update, scale_lock, acc_clr, acc_pulse
  );
endinterface

// File: rtl/softmax_seq.sv
// Softmax phase sequencer: max scan, normalize/exp/sum, probability.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, all outputs 0
// MAX   | input mem -> get_max -> im1
// NES   | im1 -> norm_exp_sum -> im2, scale locked, sum accumulated
// PROB  | im2 -> proab_calu -> output mem
// DONE  | one-cycle done pulse, phase still reports 3
//
// Each phase runs an issue counter, a valid shift register matching the
// read + stage latency, and a write counter. All outputs are registered:
// they are computed from the next-state values so they line up with the
// state they describe.
module softmax_seq #(
  parameter int AW        = 10,
  parameter int DATA_SIZE = 1024,
  parameter int RD_LAT    = 2,
  parameter int MAX_LAT   = 1,
  parameter int NES_LAT   = 20,
  parameter int PROB_LAT  = 30
) (
  input  logic         clk,
  input  logic         rst,
  softmax_seq_if.slave bus
);

  localparam int D_MAX  = RD_LAT + MAX_LAT;
  localparam int D_NES  = RD_LAT + NES_LAT;
  localparam int D_PROB = RD_LAT + PROB_LAT;
  localparam int D_MN   = (D_MAX > D_NES) ? D_MAX : D_NES;
  localparam int D_TOP  = (D_MN > D_PROB) ? D_MN : D_PROB;

  localparam logic [AW:0] N_L    = DATA_SIZE[AW:0];
  localparam logic [AW:0] LAST_L = N_L - {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_MAX, S_NES, S_PROB, S_DONE} state_t;

  state_t           state, nxt_state;
  logic [AW:0]      iss_cnt, nxt_iss;
  logic [AW:0]      wr_cnt, nxt_wr;
  logic [D_TOP-1:0] vld_sr, nxt_sr;
  logic             loaded;
  logic             issue_v, wr_v, upd_v;
  logic [1:0]       nxt_phase;

  // Next-state and per-phase counter/shift-register update.
  always_comb begin
    nxt_state = state;
    nxt_iss   = '0;
    nxt_wr    = '0;
    nxt_sr    = '0;
    nxt_phase = 2'd0;
    issue_v   = 1'b0;
    wr_v      = 1'b0;

    case (state)
      S_MAX:   wr_v = vld_sr[D_MAX-1];
      S_NES:   wr_v = vld_sr[D_NES-1];
      S_PROB:  wr_v = vld_sr[D_PROB-1];
      default: wr_v = 1'b0;
    endcase
    issue_v = (state inside {S_MAX, S_NES, S_PROB}) && (iss_cnt < N_L);

    case (state)
      S_IDLE: if (bus.start) nxt_state = S_MAX;
      S_MAX, S_NES, S_PROB: begin
        if (wr_v && wr_cnt == LAST_L) begin
          // final write of the phase: counters restart for the next one
          case (state)
            S_MAX:   nxt_state = S_NES;
            S_NES:   nxt_state = S_PROB;
            default: nxt_state = S_DONE;
          endcase
        end else begin
          nxt_iss = iss_cnt + {{AW{1'b0}}, issue_v};
          nxt_wr  = wr_cnt + {{AW{1'b0}}, wr_v};
          nxt_sr  = {vld_sr[D_TOP-2:0], issue_v};
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    case (nxt_state)
      S_MAX:          nxt_phase = 2'd1;
      S_NES:          nxt_phase = 2'd2;
      S_PROB, S_DONE: nxt_phase = 2'd3;
      default:        nxt_phase = 2'd0;
    endcase

    // element reaches get_max RD_LAT cycles after its read was issued
    upd_v = (nxt_state == S_MAX) && nxt_sr[RD_LAT-1];
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      iss_cnt          <= '0;
      wr_cnt           <= '0;
      vld_sr           <= '0;
      loaded           <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.phase        <= 2'd0;
      bus.rd_addr      <= '0;
      bus.im1_wr_ena   <= 1'b0;
      bus.im1_wr_addr  <= '0;
      bus.im1_rd_addr  <= '0;
      bus.im2_wr_ena   <= 1'b0;
      bus.im2_wr_addr  <= '0;
      bus.im2_rd_addr  <= '0;
      bus.wr_ena       <= 1'b0;
      bus.wr_addr      <= '0;
      bus.scale_update <= 2'b00;
      bus.scale_lock   <= 1'b0;
      bus.acc_clr      <= 1'b0;
      bus.acc_pulse    <= 1'b0;
    end else begin
      state   <= nxt_state;
      iss_cnt <= nxt_iss;
      wr_cnt  <= nxt_wr;
      vld_sr  <= nxt_sr;

      if (nxt_state != S_MAX) loaded <= 1'b0;
      else if (upd_v)         loaded <= 1'b1;

      bus.busy  <= (nxt_state != S_IDLE);
      bus.done  <= (nxt_state == S_DONE);
      bus.phase <= nxt_phase;

      bus.rd_addr      <= (nxt_state == S_MAX) ? nxt_iss[AW-1:0] : '0;
      bus.im1_wr_ena   <= (nxt_state == S_MAX) && nxt_sr[D_MAX-1];
      bus.im1_wr_addr  <= (nxt_state == S_MAX) ? nxt_wr[AW-1:0] : '0;
      bus.scale_update <= upd_v ? (loaded ? 2'b10 : 2'b01) : 2'b00;

      bus.im1_rd_addr  <= (nxt_state == S_NES) ? nxt_iss[AW-1:0] : '0;
      bus.im2_wr_ena   <= (nxt_state == S_NES) && nxt_sr[D_NES-1];
      bus.acc_pulse    <= (nxt_state == S_NES) && nxt_sr[D_NES-1];
      bus.im2_wr_addr  <= (nxt_state == S_NES) ? nxt_wr[AW-1:0] : '0;
      bus.scale_lock   <= (nxt_state == S_NES);
      bus.acc_clr      <= (nxt_state == S_NES) && (state == S_MAX);

      bus.im2_rd_addr  <= (nxt_state == S_PROB) ? nxt_iss[AW-1:0] : '0;
      bus.wr_ena       <= (nxt_state == S_PROB) && nxt_sr[D_PROB-1];
      bus.wr_addr      <= (nxt_state == S_PROB) ? nxt_wr[AW-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_softmax_seq.sv
// Self-checking bench for softmax_seq: a small configuration (AW=3, 8
// elements) and the default configuration, compared cycle by cycle against
// an arithmetic model of the phase timing.
module tb_softmax_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s = 1'b1;
  logic rst_d = 1'b1;

  softmax_seq_if #(.AW(3))  bus_s ();
  softmax_seq_if #(.AW(10)) bus_d ();

  softmax_seq #(.AW(3), .DATA_SIZE(8), .RD_LAT(2), .MAX_LAT(1),
                .NES_LAT(4), .PROB_LAT(6))
    dut_s (.clk(clk), .rst(rst_s), .bus(bus_s));

  softmax_seq dut_d (.clk(clk), .rst(rst_d), .bus(bus_d));

  typedef struct packed {
    logic [15:0] busy, done, phase, rd, im1e, im1a, im1r, im2e, im2a, im2r,
                 we, wa, su, sl, ac, ap;
  } vec_t;

  int errors = 0;
  int checks = 0;

  vec_t obs_s, obs_d;

  // Collect each DUT's outputs into one comparable vector.
  always_comb begin
    obs_s       = '0;
    obs_s.busy  = 16'(bus_s.busy);
    obs_s.done  = 16'(bus_s.done);
    obs_s.phase = 16'(bus_s.phase);
    obs_s.rd    = 16'(bus_s.rd_addr);
    obs_s.im1e  = 16'(bus_s.im1_wr_ena);
    obs_s.im1a  = 16'(bus_s.im1_wr_addr);
    obs_s.im1r  = 16'(bus_s.im1_rd_addr);
    obs_s.im2e  = 16'(bus_s.im2_wr_ena);
    obs_s.im2a  = 16'(bus_s.im2_wr_addr);
    obs_s.im2r  = 16'(bus_s.im2_rd_addr);
    obs_s.we    = 16'(bus_s.wr_ena);
    obs_s.wa    = 16'(bus_s.wr_addr);
    obs_s.su    = 16'(bus_s.scale_update);
    obs_s.sl    = 16'(bus_s.scale_lock);
    obs_s.ac    = 16'(bus_s.acc_clr);
    obs_s.ap    = 16'(bus_s.acc_pulse);
  end

  always_comb begin
    obs_d       = '0;
    obs_d.busy  = 16'(bus_d.busy);
    obs_d.done  = 16'(bus_d.done);
    obs_d.phase = 16'(bus_d.phase);
    obs_d.rd    = 16'(bus_d.rd_addr);
    obs_d.im1e  = 16'(bus_d.im1_wr_ena);
    obs_d.im1a  = 16'(bus_d.im1_wr_addr);
    obs_d.im1r  = 16'(bus_d.im1_rd_addr);
    obs_d.im2e  = 16'(bus_d.im2_wr_ena);
    obs_d.im2a  = 16'(bus_d.im2_wr_addr);
    obs_d.im2r  = 16'(bus_d.im2_rd_addr);
    obs_d.we    = 16'(bus_d.wr_ena);
    obs_d.wa    = 16'(bus_d.wr_addr);
    obs_d.su    = 16'(bus_d.scale_update);
    obs_d.sl    = 16'(bus_d.scale_lock);
    obs_d.ac    = 16'(bus_d.acc_clr);
    obs_d.ap    = 16'(bus_d.acc_pulse);
  end

  // Expected outputs in cycle c of a run (cycle 1 = first MAX cycle).
  function automatic vec_t model(int c, int aw, int n, int rl, int ml,
                                 int nl, int pl);
    vec_t e;
    int l1, l2, l3, ph, k, d, ra, wa, mask;
    logic wen;
    e    = '0;
    mask = (1 << aw) - 1;
    l1   = n + rl + ml;
    l2   = n + rl + nl;
    l3   = n + rl + pl;
    if (c < 1 || c > l1 + l2 + l3 + 1) return e;
    e.busy = 16'd1;
    if (c == l1 + l2 + l3 + 1) begin
      e.done  = 16'd1;
      e.phase = 16'd3;
      return e;
    end
    if (c <= l1) begin
      ph = 1; k = c - 1; d = rl + ml;
    end else if (c <= l1 + l2) begin
      ph = 2; k = c - 1 - l1; d = rl + nl;
    end else begin
      ph = 3; k = c - 1 - l1 - l2; d = rl + pl;
    end
    e.phase = 16'(ph);
    ra  = ((k < n) ? k : n) & mask;
    wen = (k >= d) && (k < d + n);
    wa  = k - d;
    if (wa < 0) wa = 0;
    if (wa > n) wa = n;
    wa  = wa & mask;
    if (ph == 1) begin
      e.rd   = 16'(ra);
      e.im1e = 16'(wen);
      e.im1a = 16'(wa);
      if (k == rl)                  e.su = 16'd1;
      else if (k > rl && k < rl + n) e.su = 16'd2;
    end else if (ph == 2) begin
      e.im1r = 16'(ra);
      e.im2e = 16'(wen);
      e.ap   = 16'(wen);
      e.im2a = 16'(wa);
      e.sl   = 16'd1;
      e.ac   = 16'(k == 0);
    end else begin
      e.im2r = 16'(ra);
      e.we   = 16'(wen);
      e.wa   = 16'(wa);
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_s = 1'b1;
    bus_s.start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (obs_s !== '0) begin
        errors++;
        $display("FAIL reset_outputs got=%h exp=0", obs_s);
      end
    end
    rst_s = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_s.phase !== 2'd1 || bus_s.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_max got phase=%0d busy=%0d exp phase=1 busy=1",
               bus_s.phase, bus_s.busy);
    end
    bus_s.start = 1'b0;
    rst_s = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0;
  endtask

  task automatic test_small_run();
    vec_t e;
    int n1 = 0, n2 = 0, n3 = 0, nap = 0, nsu1 = 0, nsu2 = 0;
    int nclr = 0, clr_cyc = -1, ndone = 0, done_cyc = -1;
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 bus_s.start = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      @(posedge clk); #1;
      bus_s.start = 1'b0;
      e = model(c, 3, 8, 2, 1, 4, 6);
      checks++;
      if (obs_s !== e) begin
        errors++;
        $display("FAIL small_cycle_%0d got=%h exp=%h", c, obs_s, e);
      end
      if (bus_s.im1_wr_ena) begin
        checks++;
        if (bus_s.im1_wr_addr !== 3'(n1)) begin
          errors++;
          $display("FAIL small_im1_addr got=%0d exp=%0d", bus_s.im1_wr_addr, n1);
        end
        n1++;
      end
      if (bus_s.im2_wr_ena) begin
        checks++;
        if (bus_s.im2_wr_addr !== 3'(n2)) begin
          errors++;
          $display("FAIL small_im2_addr got=%0d exp=%0d", bus_s.im2_wr_addr, n2);
        end
        n2++;
      end
      if (bus_s.wr_ena) begin
        checks++;
        if (bus_s.wr_addr !== 3'(n3)) begin
          errors++;
          $display("FAIL small_wr_addr got=%0d exp=%0d", bus_s.wr_addr, n3);
        end
        n3++;
      end
      if (bus_s.acc_pulse) nap++;
      if (bus_s.scale_update == 2'b01) nsu1++;
      if (bus_s.scale_update == 2'b10) nsu2++;
      if (bus_s.acc_clr) begin nclr++; clr_cyc = c; end
      if (bus_s.done) begin ndone++; done_cyc = c; end
    end
    checks++;
    if (n1 != 8 || n2 != 8 || n3 != 8) begin
      errors++;
      $display("FAIL small_write_counts got=%0d/%0d/%0d exp=8/8/8", n1, n2, n3);
    end
    checks++;
    if (nap != 8) begin
      errors++;
      $display("FAIL small_acc_pulse got=%0d exp=8", nap);
    end
    checks++;
    if (nsu1 != 1 || nsu2 != 7) begin
      errors++;
      $display("FAIL small_scale_update got=%0d/%0d exp=1/7", nsu1, nsu2);
    end
    checks++;
    if (nclr != 1 || clr_cyc != 12) begin
      errors++;
      $display("FAIL small_acc_clr got count=%0d cycle=%0d exp count=1 cycle=12",
               nclr, clr_cyc);
    end
    checks++;
    if (ndone != 1 || done_cyc != 42) begin
      errors++;
      $display("FAIL small_done got count=%0d cycle=%0d exp count=1 cycle=42",
               ndone, done_cyc);
    end
  endtask

  task automatic test_start_ignored();
    vec_t e;
    int p_max, p_nes, p_any, ndone = 0, nwr = 0;
    p_max = $urandom_range(1, 11);
    p_nes = $urandom_range(12, 25);
    p_any = $urandom_range(2, 41);
    #1 bus_s.start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      bus_s.start = (c == p_max) || (c == p_nes) || (c == p_any) || (c == 42);
      e = model(c, 3, 8, 2, 1, 4, 6);
      checks++;
      if (obs_s !== e) begin
        errors++;
        $display("FAIL ignored_cycle_%0d got=%h exp=%h", c, obs_s, e);
      end
      if (bus_s.done) ndone++;
      if (bus_s.wr_ena) nwr++;
    end
    bus_s.start = 1'b0;
    checks++;
    if (ndone != 1 || nwr != 8) begin
      errors++;
      $display("FAIL ignored_totals got done=%0d writes=%0d exp done=1 writes=8",
               ndone, nwr);
    end
  endtask

  task automatic test_reset_mid();
    vec_t e;
    int rc, nwr;
    for (int pass = 0; pass < 2; pass++) begin
      rc = (pass == 0) ? 20 : $urandom_range(2, 41);
      #1 bus_s.start = 1'b1;
      for (int c = 1; c <= rc; c++) begin
        @(posedge clk); #1;
        bus_s.start = 1'b0;
        e = model(c, 3, 8, 2, 1, 4, 6);
        checks++;
        if (obs_s !== e) begin
          errors++;
          $display("FAIL rstmid_pre_cycle_%0d got=%h exp=%h", c, obs_s, e);
        end
      end
      rst_s = 1'b1;
      for (int c = rc + 1; c <= rc + 20; c++) begin
        @(posedge clk); #1;
        rst_s = 1'b0;
        checks++;
        if (obs_s !== '0) begin
          errors++;
          $display("FAIL rstmid_post_cycle_%0d got=%h exp=0", c, obs_s);
        end
      end
    end
    nwr = 0;
    #1 bus_s.start = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(posedge clk); #1;
      bus_s.start = 1'b0;
      e = model(c, 3, 8, 2, 1, 4, 6);
      checks++;
      if (obs_s !== e) begin
        errors++;
        $display("FAIL rstmid_rerun_cycle_%0d got=%h exp=%h", c, obs_s, e);
      end
      if (bus_s.wr_ena) nwr++;
    end
    checks++;
    if (nwr != 8) begin
      errors++;
      $display("FAIL rstmid_rerun_writes got=%0d exp=8", nwr);
    end
  endtask

  task automatic test_start_held();
    vec_t e;
    int last_wa = -1;
    #1 bus_s.start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      e = (c <= 43) ? model(c, 3, 8, 2, 1, 4, 6) : model(c - 43, 3, 8, 2, 1, 4, 6);
      checks++;
      if (obs_s !== e) begin
        errors++;
        $display("FAIL held_cycle_%0d got=%h exp=%h", c, obs_s, e);
      end
      if (c <= 43 && bus_s.wr_ena) last_wa = int'(bus_s.wr_addr);
      if (c == 44) begin
        checks++;
        if (bus_s.phase !== 2'd1) begin
          errors++;
          $display("FAIL held_second_run got phase=%0d exp=1", bus_s.phase);
        end
      end
    end
    checks++;
    if (last_wa != 7) begin
      errors++;
      $display("FAIL held_last_wr_addr got=%0d exp=7", last_wa);
    end
    bus_s.start = 1'b0;
    rst_s = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0;
  endtask

  task automatic test_defaults();
    vec_t e;
    int nwr = 0, ndone = 0, done_cyc = -1;
    rst_d = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs_d !== '0) begin
      errors++;
      $display("FAIL dflt_idle got=%h exp=0", obs_d);
    end
    bus_d.start = 1'b1;
    for (int c = 1; c <= 3133; c++) begin
      @(posedge clk); #1;
      bus_d.start = 1'b0;
      e = model(c, 10, 1024, 2, 1, 20, 30);
      checks++;
      if (obs_d !== e) begin
        errors++;
        $display("FAIL dflt_cycle_%0d got=%h exp=%h", c, obs_d, e);
      end
      if (bus_d.wr_ena) begin
        checks++;
        if (bus_d.wr_addr !== 10'(nwr)) begin
          errors++;
          $display("FAIL dflt_wr_addr got=%0d exp=%0d", bus_d.wr_addr, nwr);
        end
        nwr++;
      end
      if (bus_d.done) begin ndone++; done_cyc = c; end
    end
    checks++;
    if (nwr != 1024) begin
      errors++;
      $display("FAIL dflt_wr_count got=%0d exp=1024", nwr);
    end
    checks++;
    if (ndone != 1 || done_cyc != 3130) begin
      errors++;
      $display("FAIL dflt_done got count=%0d cycle=%0d exp count=1 cycle=3130",
               ndone, done_cyc);
    end
  endtask

  initial begin
    bus_s.start = 1'b0;
    bus_d.start = 1'b0;
    test_reset();
    test_small_run();
    test_start_ignored();
    test_reset_mid();
    test_start_held();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
